ising_array_ctrl: RTL and testbench

//  Synchronous initiator for the 50x50 Ising array macro. It programs coupling weights row by row

---
 rtl/ising_array_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_ising_array_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ising_array_ctrl.sv
// Sequencer for the 50x50 Ising array: programs one weight row per host write and runs
// one anneal per start (precharge, oscillate, sample, capture). Array strobes are all flopped.
module ising_array_ctrl #(
    parameter int ROWS          = 50,
    parameter int WBL_W         = 200,
    parameter int SPIN_W        = 350,
    parameter int PRECHARGE_CYC = 4,
    parameter int WPULSE_CYC    = 2,
    parameter int SAMPLE_CYC    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [5:0]        wr_row,
    input  logic [WBL_W-1:0]  wr_data,
    output logic              wr_err,
    input  logic              shil_sel,
    input  logic              start,
    input  logic [15:0]       run_cycles,
    output logic              busy,
    output logic              done,
    output logic [SPIN_W-1:0] spin_data,
    output logic [ROWS-1:0]   WWL,
    output logic [WBL_W-1:0]  WBL,
    output logic              WEIGHT_ENB,
    output logic              SHIL_WEIGHT_ENB,
    output logic              PRE_CHARGE_ENB,
    output logic              ROSC_GLOBAL_EN,
    output logic              SAMPLE,
    input  logic [SPIN_W-1:0] SPIN_OUT
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_W_SETUP = 3'd1;
    localparam logic [2:0] S_W_PULSE = 3'd2;
    localparam logic [2:0] S_W_HOLD  = 3'd3;
    localparam logic [2:0] S_PRECH   = 3'd4;
    localparam logic [2:0] S_RUN     = 3'd5;
    localparam logic [2:0] S_SMPL    = 3'd6;
    localparam logic [2:0] S_CAPT    = 3'd7;

    localparam logic [6:0]  ROWS_LIM   = 7'(ROWS);
    localparam logic [15:0] PRECH_LOAD = 16'(PRECHARGE_CYC - 1);
    localparam logic [15:0] WP_LOAD    = 16'(WPULSE_CYC - 1);
    localparam logic [15:0] SMPL_LOAD  = 16'(SAMPLE_CYC - 1);

    logic [2:0]        state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [15:0]       run_len_q, run_len_d;
    logic [5:0]        row_q, row_d;
    logic              shil_q, shil_d;
    logic [WBL_W-1:0]  wbl_q, wbl_d;
    logic [ROWS-1:0]   wwl_q, wwl_d;
    logic              weight_enb_q, weight_enb_d;
    logic              shil_enb_q, shil_enb_d;
    logic              prech_enb_q, prech_enb_d;
    logic              rosc_q, rosc_d;
    logic              sample_q, sample_d;
    logic [SPIN_W-1:0] spin_q, spin_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              writing;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        run_len_d = run_len_q;
        row_d     = row_q;
        shil_d    = shil_q;
        wbl_d     = wbl_q;
        spin_d    = spin_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    run_len_d = (run_cycles == 16'd0) ? 16'd1 : run_cycles;
                    cnt_d     = PRECH_LOAD;
                    state_d   = S_PRECH;
                end else if (wr_valid) begin
                    if ({1'b0, wr_row} >= ROWS_LIM) begin
                        err_d = 1'b1;
                    end else begin
                        row_d   = wr_row;
                        shil_d  = shil_sel;
                        wbl_d   = wr_data;
                        state_d = S_W_SETUP;
                    end
                end
            end
            S_W_SETUP: begin
                cnt_d   = WP_LOAD;
                state_d = S_W_PULSE;
            end
            S_W_PULSE: begin
                if (cnt_q == 16'd0) state_d = S_W_HOLD;
                else                cnt_d   = cnt_q - 16'd1;
            end
            S_W_HOLD: state_d = S_IDLE;
            S_PRECH: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = run_len_q - 16'd1;
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_RUN: begin
                if (cnt_q == 16'd0) begin
                    cnt_d   = SMPL_LOAD;
                    state_d = S_SMPL;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_SMPL: begin
                if (cnt_q == 16'd0) state_d = S_CAPT;
                else                cnt_d   = cnt_q - 16'd1;
            end
            S_CAPT: begin
                spin_d  = SPIN_OUT;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes derive from the next state so they change on the same edge as the FSM.
        writing      = (state_d == S_W_SETUP) || (state_d == S_W_PULSE) || (state_d == S_W_HOLD);
        wwl_d        = (state_d == S_W_PULSE) ? ({{(ROWS-1){1'b0}}, 1'b1} << row_d) : '0;
        weight_enb_d = ~(writing & ~shil_d);
        shil_enb_d   = ~(writing & shil_d);
        prech_enb_d  = (state_d != S_PRECH);
        rosc_d       = (state_d == S_RUN) || (state_d == S_SMPL);
        sample_d     = (state_d == S_SMPL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            run_len_q    <= 16'd1;
            row_q        <= '0;
            shil_q       <= 1'b0;
            wbl_q        <= '0;
            wwl_q        <= '0;
            weight_enb_q <= 1'b1;
            shil_enb_q   <= 1'b1;
            prech_enb_q  <= 1'b1;
            rosc_q       <= 1'b0;
            sample_q     <= 1'b0;
            spin_q       <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            run_len_q    <= run_len_d;
            row_q        <= row_d;
            shil_q       <= shil_d;
            wbl_q        <= wbl_d;
            wwl_q        <= wwl_d;
            weight_enb_q <= weight_enb_d;
            shil_enb_q   <= shil_enb_d;
            prech_enb_q  <= prech_enb_d;
            rosc_q       <= rosc_d;
            sample_q     <= sample_d;
            spin_q       <= spin_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Reset also masks ready so the host never sees a handshake while the block is held.
    assign wr_ready        = rst_n & (state_q == S_IDLE) & ~start;
    assign busy            = (state_q != S_IDLE);
    assign done            = done_q;
    assign wr_err          = err_q;
    assign spin_data       = spin_q;
    assign WWL             = wwl_q;
    assign WBL             = wbl_q;
    assign WEIGHT_ENB      = weight_enb_q;
    assign SHIL_WEIGHT_ENB = shil_enb_q;
    assign PRE_CHARGE_ENB  = prech_enb_q;
    assign ROSC_GLOBAL_EN  = rosc_q;
    assign SAMPLE          = sample_q;

endmodule

// File: tb/tb_ising_array_ctrl.sv
// Directed/randomized bench for ising_array_ctrl: traces each transaction cycle by cycle
// and compares pulse widths, positions and captured data against a timing model and array model.
module tb_ising_array_ctrl;

    localparam int ROWS  = 50;
    localparam int WBL_W = 200;
    localparam int SPW   = 350;
    localparam int P     = 4;
    localparam int WP    = 2;
    localparam int S     = 2;
    localparam int HMAX  = 96;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             wr_valid = 1'b0;
    logic             shil_sel = 1'b0;
    logic             start = 1'b0;
    logic [5:0]       wr_row = '0;
    logic [WBL_W-1:0] wr_data = '0;
    logic [15:0]      run_cycles = '0;
    logic [SPW-1:0]   spin_out = '0;
    logic             wr_ready, wr_err, busy, done;
    logic [SPW-1:0]   spin_data;
    logic [ROWS-1:0]  WWL;
    logic [WBL_W-1:0] WBL;
    logic             WEIGHT_ENB, SHIL_WEIGHT_ENB, PRE_CHARGE_ENB, ROSC_GLOBAL_EN, SAMPLE;

    logic [ROWS-1:0]  h_wwl  [HMAX];
    logic [WBL_W-1:0] h_wbl  [HMAX];
    logic [SPW-1:0]   h_spin [HMAX];
    logic h_wenb [HMAX];
    logic h_senb [HMAX];
    logic h_prech[HMAX];
    logic h_rosc [HMAX];
    logic h_smpl [HMAX];
    logic h_done [HMAX];
    logic h_err  [HMAX];
    logic h_ready[HMAX];
    logic h_busy [HMAX];

    int compared   = 0;
    int mismatched = 0;
    logic [SPW-1:0]   model_pattern = '0;
    logic [SPW-1:0]   spin_model    = '0;
    logic [WBL_W-1:0] wbl_model     = '0;

    ising_array_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_data(wr_data),
        .wr_err(wr_err), .shil_sel(shil_sel), .start(start), .run_cycles(run_cycles),
        .busy(busy), .done(done), .spin_data(spin_data),
        .WWL(WWL), .WBL(WBL), .WEIGHT_ENB(WEIGHT_ENB), .SHIL_WEIGHT_ENB(SHIL_WEIGHT_ENB),
        .PRE_CHARGE_ENB(PRE_CHARGE_ENB), .ROSC_GLOBAL_EN(ROSC_GLOBAL_EN), .SAMPLE(SAMPLE),
        .SPIN_OUT(spin_out)
    );

    always #5 clk = ~clk;

    function automatic logic [SPW-1:0] rand_spin();
        logic [351:0] t;
        for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom;
        return t[SPW-1:0];
    endfunction

    function automatic logic [WBL_W-1:0] rand_wbl();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
        return t[WBL_W-1:0];
    endfunction

    // Array model: a fresh spin vector appears on each SAMPLE rise; precharge scrambles it.
    always @(posedge SAMPLE) begin
        spin_out      = rand_spin();
        model_pattern = spin_out;
    end

    always @(negedge PRE_CHARGE_ENB) spin_out = rand_spin();

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_output(input string tag, input logic [399:0] obs, input logic [399:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples n consecutive cycles; cycle 1 is the one right after the request edge.
    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            h_wwl[i] = WWL; h_wbl[i] = WBL; h_spin[i] = spin_data;
            h_wenb[i] = WEIGHT_ENB; h_senb[i] = SHIL_WEIGHT_ENB; h_prech[i] = PRE_CHARGE_ENB;
            h_rosc[i] = ROSC_GLOBAL_EN; h_smpl[i] = SAMPLE; h_done[i] = done;
            h_err[i] = wr_err; h_ready[i] = wr_ready; h_busy[i] = busy;
            if (i == 0) begin
                wr_valid = 1'b0;
                start    = 1'b0;
            end
            if (i == 1) run_cycles = 16'($urandom);
        end
    endtask

    task automatic apply_stimulus_write(input logic [5:0] row, input logic [WBL_W-1:0] data,
                                        input logic sel);
        int n, sel_low, oth_low, hit, bad, err_cnt, err_first, busy_cnt, ready_first;
        logic [ROWS-1:0] oh;
        bit valid;
        n = WP + 4;
        valid = (int'(row) < ROWS);
        oh = '0;
        if (valid) oh[row] = 1'b1;
        @(negedge clk);
        wr_valid = 1'b1; wr_row = row; wr_data = data; shil_sel = sel;
        record(n);
        sel_low = 0; oth_low = 0; hit = 0; bad = 0; err_cnt = 0; err_first = -1;
        busy_cnt = 0; ready_first = -1;
        for (int i = 0; i < n; i++) begin
            if (!(sel ? h_senb[i] : h_wenb[i])) sel_low++;
            if (!(sel ? h_wenb[i] : h_senb[i])) oth_low++;
            if (valid && h_wwl[i] == oh) hit++;
            else if (h_wwl[i] != '0) bad++;
            if (h_err[i]) begin
                err_cnt++;
                if (err_first < 0) err_first = i + 1;
            end
            if (h_busy[i]) busy_cnt++;
            if (h_ready[i] && ready_first < 0) ready_first = i + 1;
        end
        if (valid) begin
            wbl_model = data;
            check_output("wr_sel_enb_low", 400'(sel_low), 400'(WP + 2));
            check_output("wr_wwl_onehot", 400'(hit), 400'(WP));
            check_output("wr_wwl_first", 400'(h_wwl[0]), 400'(0));
            check_output("wr_wbl_setup", 400'(h_wbl[0]), 400'(data));
            check_output("wr_ready_back", 400'(ready_first), 400'(WP + 3));
            check_output("wr_no_err", 400'(err_cnt), 400'(0));
        end else begin
            check_output("err_pulse_cnt", 400'(err_cnt), 400'(1));
            check_output("err_pulse_cycle", 400'(err_first), 400'(1));
            check_output("err_enb_low", 400'(sel_low), 400'(0));
            check_output("err_busy", 400'(busy_cnt), 400'(0));
        end
        check_output("wr_other_enb", 400'(oth_low), 400'(0));
        check_output("wr_wwl_bad", 400'(bad), 400'(0));
        check_output("wr_wbl_final", 400'(h_wbl[n-1]), 400'(wbl_model));
    endtask

    task automatic apply_stimulus_anneal(input logic [15:0] n_in, input logic with_wr);
        int neff, len, pre_cnt, pre_first, rosc_cnt, rosc_first, smp_cnt, smp_first;
        int done_cnt, done_at, enb_low;
        logic [SPW-1:0] spin_at_done;
        neff = (n_in == 16'd0) ? 1 : int'(n_in);
        len  = P + neff + S + 4;
        @(negedge clk);
        start = 1'b1; run_cycles = n_in; wr_valid = with_wr;
        wr_row = 6'($urandom_range(0, ROWS - 1)); wr_data = rand_wbl(); shil_sel = 1'b0;
        record(len);
        pre_cnt = 0; pre_first = -1; rosc_cnt = 0; rosc_first = -1; smp_cnt = 0; smp_first = -1;
        done_cnt = 0; done_at = -1; enb_low = 0; spin_at_done = '0;
        for (int i = 0; i < len; i++) begin
            if (!h_prech[i]) begin pre_cnt++; if (pre_first < 0) pre_first = i + 1; end
            if (h_rosc[i]) begin rosc_cnt++; if (rosc_first < 0) rosc_first = i + 1; end
            if (h_smpl[i]) begin smp_cnt++; if (smp_first < 0) smp_first = i + 1; end
            if (h_done[i]) begin
                done_cnt++;
                if (done_at < 0) begin done_at = i + 1; spin_at_done = h_spin[i]; end
            end
            if (!h_wenb[i] || !h_senb[i]) enb_low++;
        end
        check_output("an_prech_len", 400'(pre_cnt), 400'(P));
        check_output("an_prech_first", 400'(pre_first), 400'(1));
        check_output("an_rosc_len", 400'(rosc_cnt), 400'(neff + S));
        check_output("an_rosc_first", 400'(rosc_first), 400'(P + 1));
        check_output("an_sample_len", 400'(smp_cnt), 400'(S));
        check_output("an_sample_first", 400'(smp_first), 400'(P + neff + 1));
        check_output("an_done_cnt", 400'(done_cnt), 400'(1));
        check_output("an_done_cycle", 400'(done_at), 400'(P + neff + S + 2));
        check_output("an_no_write", 400'(enb_low), 400'(0));
        check_output("an_busy", 400'({h_busy[0], h_busy[len-1]}), 400'(2'b10));
        check_output("an_spin_hold", 400'(h_spin[0]), 400'(spin_model));
        spin_model = model_pattern;
        check_output("an_spin_capture", 400'(spin_at_done), 400'(spin_model));
    endtask

    initial begin
        int rosc_cnt, done_cnt, busy_cnt;
        $display("[TB] start");
        repeat (3) @(negedge clk);
        check_output("rst_outputs",
                     400'({wr_ready, busy, done, wr_err, WEIGHT_ENB, SHIL_WEIGHT_ENB,
                           PRE_CHARGE_ENB, ROSC_GLOBAL_EN, SAMPLE}), 400'(9'b000011100));
        check_output("rst_wwl", 400'(WWL), 400'(0));
        check_output("rst_wbl", 400'(WBL), 400'(0));
        check_output("rst_spin", 400'(spin_data), 400'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check_output("idle_ready", 400'(wr_ready), 400'(1));

        apply_stimulus_write(6'd7, {25{8'hA5}}, 1'b0);
        apply_stimulus_write(6'd50, rand_wbl(), 1'b0);
        apply_stimulus_write(6'd0, rand_wbl(), 1'b1);
        apply_stimulus_anneal(16'd10, 1'b0);
        apply_stimulus_anneal(16'd0, 1'b0);
        apply_stimulus_anneal(16'($urandom_range(1, 8)), 1'b1);
        @(negedge clk);
        check_output("write_not_queued", 400'({WEIGHT_ENB, SHIL_WEIGHT_ENB, busy}), 400'(3'b110));

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        start = 1'b1; run_cycles = 16'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (P + 2) @(negedge clk);
        check_output("pre_reset_rosc", 400'(ROSC_GLOBAL_EN), 400'(1));
        #2 rst_n = 1'b0;
        #1;
        check_output("async_rst_strobes",
                     400'({ROSC_GLOBAL_EN, PRE_CHARGE_ENB, SAMPLE, WEIGHT_ENB, busy, done, wr_ready}),
                     400'(7'b0101000));
        check_output("async_rst_wwl", 400'(WWL), 400'(0));
        check_output("async_rst_spin", 400'(spin_data), 400'(0));
        @(negedge clk);
        rst_n = 1'b1;
        spin_model = '0;
        wbl_model  = '0;
        record(30);
        rosc_cnt = 0; done_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (h_rosc[i]) rosc_cnt++;
            if (h_done[i]) done_cnt++;
            if (h_busy[i]) busy_cnt++;
        end
        check_output("post_rst_quiet", 400'({rosc_cnt, done_cnt, busy_cnt}), 400'(0));

        for (int r = 0; r < ROWS; r++)
            apply_stimulus_write(6'(r), rand_wbl(), 1'($urandom_range(0, 1)));
        apply_stimulus_write(6'($urandom_range(ROWS, 63)), rand_wbl(), 1'($urandom_range(0, 1)));
        apply_stimulus_anneal(16'($urandom_range(0, 15)), 1'b0);
        apply_stimulus_anneal(16'($urandom_range(0, 15)), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
